// File: rtl/ras.sv
// Return address stack for the front-end branch predictor.
//
// A circular stack of predicted return targets. Predicted calls push their return address, predicted
// returns pop, and the entry under the top pointer is presented as the predicted return target. The
// top pointer and occupancy form a checkpoint that the backend can restore on a flush. Only the
// pointer and occupancy are restored; the entries themselves are not.
//
// Ports:
//   CLK               clock
//   nRST              asynchronous active-low reset
//   link_valid        push request (predicted call)
//   link_pc           return address to push
//   ret_valid         pop request (predicted return)
//   ret_pc            entry under the top pointer (predicted return target)
//   ret_empty         occupancy is zero; qualifies ret_pc
//   ras_index         top pointer (checkpoint)
//   ras_count         occupancy 0..RAS_DEPTH (checkpoint)
//   update_valid      restore checkpoint; overrides push/pop in the same cycle
//   update_ras_index  top pointer to restore
//   update_ras_count  occupancy to restore
module ras #(
  parameter int unsigned RAS_DEPTH        = 8,
  parameter int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int unsigned RAS_TARGET_WIDTH = 14
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
  input  logic                        ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_pc,
  output logic                        ret_empty,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index,
  output logic [LOG_RAS_DEPTH:0]      ras_count,
  input  logic                        update_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    update_ras_index,
  input  logic [LOG_RAS_DEPTH:0]      update_ras_count
);

  localparam logic [LOG_RAS_DEPTH-1:0] PtrOne   = LOG_RAS_DEPTH'(1);
  localparam logic [LOG_RAS_DEPTH:0]   CntOne   = (LOG_RAS_DEPTH + 1)'(1);
  localparam logic [LOG_RAS_DEPTH:0]   DepthCnt = (LOG_RAS_DEPTH + 1)'(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d;
  logic [LOG_RAS_DEPTH:0]      count_q, count_d;
  logic [LOG_RAS_DEPTH-1:0]    ptr_inc, ptr_dec;

  // Pointer wraps naturally at the power-of-two depth.
  assign ptr_inc = ptr_q + PtrOne;
  assign ptr_dec = ptr_q - PtrOne;

  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (update_valid) begin
      ptr_d   = update_ras_index;
      count_d = update_ras_count;
    end else begin
      unique case ({link_valid, ret_valid})
        2'b10: begin
          // On overflow the oldest entry is overwritten; occupancy saturates.
          ptr_d          = ptr_inc;
          stack_d[ptr_inc] = link_pc;
          count_d        = (count_q == DepthCnt) ? count_q : count_q + CntOne;
        end
        2'b01: begin
          // Underflow still moves the pointer; ret_empty marks ret_pc as stale.
          ptr_d   = ptr_dec;
          count_d = (count_q == '0) ? count_q : count_q - CntOne;
        end
        2'b11: begin
          // Coroutine jump: replace the top in place.
          stack_d[ptr_q] = link_pc;
          count_d        = (count_q == '0) ? CntOne : count_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ret_pc    = stack_q[ptr_q];
  assign ras_index = ptr_q;
  assign ras_count = count_q;
  assign ret_empty = (count_q == '0);

endmodule
